// File: rtl/rv_mem_pkg.sv
// Shared definitions for the load and store data paths: funct3 codes,
// load FSM state encoding and small decode helpers.
package rv_mem_pkg;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   localparam logic [2:0] SB = 3'b000;
   localparam logic [2:0] SH = 3'b001;
   localparam logic [2:0] SW = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      RESP  = 2'b10,
      FAULT = 2'b11
   } load_state_t;

   // True for funct3 codes that are not a defined load.
   function automatic logic is_illegal_load(input logic [2:0] funct3);
      return !(funct3 inside {LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU});
   endfunction

   // Bytes never fault; halfwords need bit 0 clear; words need both low bits clear.
   function automatic logic is_misaligned_load(input logic [2:0] funct3, input logic [1:0] offset);
      logic result;
      result = 1'b0;
      case (funct3)
         LOAD_LH, LOAD_LHU: result = offset[0];
         LOAD_LW:           result = (offset != 2'b00);
         default:           result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a memory read word.
// Kept separate so a cache return path can reuse it.
module load_extract
   import rv_mem_pkg::*;
(
   input  logic [31:0] MemRData,
   input  logic [1:0]  offset,
   input  logic [2:0]  LoadControl,
   output logic [31:0] extended
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed byte and halfword lanes out of the word.
   always_comb begin
      sel_byte = MemRData[7:0];
      case (offset)
         2'd0: sel_byte = MemRData[7:0];
         2'd1: sel_byte = MemRData[15:8];
         2'd2: sel_byte = MemRData[23:16];
         2'd3: sel_byte = MemRData[31:24];
         default: sel_byte = MemRData[7:0];
      endcase
      sel_half = offset[1] ? MemRData[31:16] : MemRData[15:0];
   end

   // Extend the selected lane according to the load type; words pass through.
   always_comb begin
      extended = 32'd0;
      case (LoadControl)
         LOAD_LB:  extended = {{24{sel_byte[7]}}, sel_byte};
         LOAD_LH:  extended = {{16{sel_half[15]}}, sel_half};
         LOAD_LW:  extended = MemRData;
         LOAD_LBU: extended = {24'd0, sel_byte};
         LOAD_LHU: extended = {16'd0, sel_half};
         default:  extended = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Load unit: validates the request, runs the request/ready handshake with
// data memory under a timeout, and returns the extended load result.
module load_unit
   import rv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        LoadStart,
   input  logic [2:0]  LoadControl,
   input  logic [31:0] AddressE,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemReady,
   input  logic [31:0] MemRData,
   output logic [31:0] ReadDataM,
   output logic        LoadValid,
   output logic        LoadFault,
   output logic        LoadBusy
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   load_state_t state;
   load_state_t state_next;
   logic [7:0]  wait_count;
   logic [7:0]  wait_count_next;
   logic [7:0]  wait_count_inc;
   logic [1:0]  held_offset;
   logic [2:0]  held_control;
   logic        accept;
   logic        capture;
   logic [31:0] extracted;

   load_extract u_extract (
      .MemRData    (MemRData),
      .offset      (held_offset),
      .LoadControl (held_control),
      .extended    (extracted)
   );

   // Next-state decision; a response in the same cycle as the timeout wins.
   always_comb begin
      state_next      = state;
      wait_count_next = wait_count;
      wait_count_inc  = wait_count + 8'd1;
      accept          = 1'b0;
      capture         = 1'b0;
      case (state)
         IDLE: begin
            if (LoadStart) begin
               if (is_illegal_load(LoadControl) ||
                   is_misaligned_load(LoadControl, AddressE[1:0])) begin
                  state_next = FAULT;
               end else begin
                  state_next      = WAIT;
                  wait_count_next = 8'd0;
                  accept          = 1'b1;
               end
            end
         end
         WAIT: begin
            if (MemReady) begin
               state_next = RESP;
               capture    = 1'b1;
            end else begin
               wait_count_next = wait_count_inc;
               if (wait_count_inc == TIMEOUT_LIMIT) begin
                  state_next = FAULT;
               end
            end
         end
         RESP:    state_next = IDLE;
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, latched request and registered outputs, all derived from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         wait_count   <= 8'd0;
         held_offset  <= 2'd0;
         held_control <= 3'd0;
         MemAddr      <= 32'd0;
         ReadDataM    <= 32'd0;
         MemReq       <= 1'b0;
         LoadValid    <= 1'b0;
         LoadFault    <= 1'b0;
         LoadBusy     <= 1'b0;
      end else begin
         state      <= state_next;
         wait_count <= wait_count_next;
         MemReq     <= (state_next == WAIT);
         LoadValid  <= (state_next == RESP);
         LoadFault  <= (state_next == FAULT);
         LoadBusy   <= (state_next != IDLE);
         if (accept) begin
            MemAddr      <= {AddressE[31:2], 2'b00};
            held_offset  <= AddressE[1:0];
            held_control <= LoadControl;
         end
         if (capture) begin
            ReadDataM <= extracted;
         end
      end
   end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side counterpart to the store data path: issues a data-memory read and returns the register-file value.
- Checks alignment and funct3, drives a request/ready memory handshake, and extracts the addressed byte, halfword or word with sign or zero extension.
- Sits between the EX/MEM boundary and data memory.
- Stalls the pipeline (LoadBusy) until the load completes or faults.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before an access fault is raised. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- LoadStart  input  1  load request from EX stage; sampled only in IDLE
- LoadControl  input  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- AddressE  input  32  byte address of the load
- MemReq  output  1  read request to data memory
- MemAddr  output  32  word-aligned address ({addr[31:2],2'b00})
- MemReady  input  1  memory response strobe; MemRData is valid when this is high
- MemRData  input  32  memory read word
- ReadDataM  output  32  extracted and extended load result
- LoadValid  output  1  one-cycle pulse: ReadDataM valid
- LoadFault  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- LoadBusy  output  1  high whenever state is not IDLE (pipeline stall)

Behaviour:
- Reset (rst_n low at clk edge):
  - State goes to IDLE. MemReq, LoadValid, LoadFault and LoadBusy go to 0. ReadDataM and MemAddr go to 0. Timeout counter goes to 0.
  - Reset mid-transaction abandons the access. MemReq is low after that edge; a late MemReady is ignored.
- FSM states: IDLE, WAIT, RESP, FAULT. All outputs are registered.
- IDLE, on LoadStart:
  - Illegal funct3 (011, 110, 111) -> FAULT.
  - Misaligned access -> FAULT. Misaligned means: lh/lhu with addr[0]=1, or lw with addr[1:0]≠0. lb/lbu are never misaligned.
  - Otherwise, latch the address and LoadControl, then go to WAIT.
  - LoadStart low: stay in IDLE.
- WAIT:
  - MemReq=1. MemAddr holds the latched word address.
  - On MemReady, register the extracted data into ReadDataM and go to RESP.
  - Each cycle without MemReady increments the counter. When the counter reaches TIMEOUT_CYCLES, go to FAULT.
- RESP: LoadValid=1 for exactly one cycle, then go to IDLE.
- FAULT: LoadFault=1 for exactly one cycle, then go to IDLE. ReadDataM keeps its previous value.
- The counter clears on every entry to WAIT.
- LoadStart outside IDLE is ignored. The EX stage must hold the request while LoadBusy is high.
- LoadBusy is high in WAIT, RESP and FAULT. A new LoadStart is accepted on the cycle after RESP or FAULT.
- Latency:
  - Start accepted at edge 0. MemReq is high from edge 0.
  - A zero-wait memory (MemReady high in the first WAIT cycle) is captured at edge 1. LoadValid is high after edge 1 and falls after edge 2.
  - Throughput is one load per 3 cycles minimum.
- Extraction, with off = addr[1:0]:
  - byte = MemRData[8*off+7 : 8*off].
  - half = addr[1] ? MemRData[31:16] : MemRData[15:0].
  - lb/lh sign-extend from bit 7/15. lbu/lhu zero-extend. lw passes the word through unchanged.
- Simultaneous events: MemReady on the same cycle the timeout would fire completes the load normally, because the response wins.

Decomposition:
- Shared package rv_mem_pkg holds:
  - Funct3 localparams: LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU; the store codes SB, SH, SW are shared with the store path.
  - The 2-bit state encoding: IDLE=00, WAIT=01, RESP=10, FAULT=11.
- Sub-module load_extract: purely combinational.
  - Inputs: MemRData, offset[1:0], LoadControl.
  - Output: 32-bit extended value.
  - Reusable by a future cache path.
- FSM, counter and handshake live in load_unit.

Test Plan:
- lb at 0x1003, MemRData=0x80FF_7F01, zero-wait -> MemReq high for 1 cycle, MemAddr=0x1000; ReadDataM=0xFFFF_FF80 with LoadValid pulse 2 cycles after start.
- lhu at 0x2002, MemRData=0xBEEF_1234, MemReady after 3 wait cycles -> ReadDataM=0x0000_BEEF, LoadBusy high 5 cycles; lh on the same data -> 0xFFFF_BEEF.
- lw at 0x3001 -> no MemReq; LoadFault pulse 1 cycle after start; ReadDataM unchanged. funct3=011 at 0x3000 -> LoadFault likewise.
- lw at 0x4000, MemReady never asserted, TIMEOUT_CYCLES=16 -> MemReq high 16 cycles, then LoadFault pulse, MemReq low; MemReady arriving on the timeout cycle -> LoadValid instead of LoadFault.
- rst_n low during WAIT, then MemReady pulse -> MemReq=0, LoadBusy=0 after the reset edge; no LoadValid; next lbu at 0x5001 with 0x0000_AB00 -> 0x0000_00AB.
- LoadStart held high continuously, back-to-back lw at 0x6000/0x6004 -> second MemReq starts the cycle after the first LoadValid; no request is lost or duplicated.
